// File: rtl/game_pkg.sv
// Shared game definitions: movement states and player motion constants,
// used by the movement FSM and the animation stage.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    JUMP = 2'd2
  } movement_state;

  localparam int X_MIN      = 0;
  localparam int X_MAX      = 592;
  localparam int GROUND_Y   = 400;
  localparam int SPAWN_X    = 300;
  localparam int WALK_SPEED = 3;
  localparam int JUMP_VEL   = 12;
  localparam int GRAVITY    = 1;
  localparam int MAX_FALL   = 8;

endpackage

// File: rtl/player_movement_fsm.sv
// Player movement FSM: per-frame horizontal walking with edge clamps, and a
// gravity-driven jump arc that lands back on the ground line.
module player_movement_fsm
  import game_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_tick,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          btn_jump,
  output movement_state move_state,
  output logic [9:0]    pos_x,
  output logic [9:0]    pos_y,
  output logic          facing_left,
  output logic          on_ground
);

  localparam logic signed [10:0] X_MIN_S  = 11'(X_MIN);
  localparam logic signed [10:0] X_MAX_S  = 11'(X_MAX);
  localparam logic signed [10:0] GROUND_S = 11'(GROUND_Y);
  localparam logic signed [10:0] WALK_S   = 11'(WALK_SPEED);
  localparam logic signed [5:0]  JUMP_S   = 6'(JUMP_VEL);
  localparam logic signed [5:0]  GRAV_S   = 6'(GRAVITY);
  localparam logic signed [5:0]  FALL_S   = 6'(MAX_FALL);

  logic signed [5:0]  vy;
  logic               jump_prev;
  logic               jump_edge, left_only, right_only;
  logic signed [10:0] x_left, x_right, y_calc;
  logic [9:0]         x_next;
  logic signed [5:0]  vy_sum, vy_fall;
  movement_state      ground_state;

  always_comb begin
    jump_edge    = btn_jump & ~jump_prev;
    left_only    = btn_left & ~btn_right;
    right_only   = btn_right & ~btn_left;
    ground_state = (left_only | right_only) ? WALK : IDLE;

    // 11-bit signed intermediates so neither screen bound can wrap.
    x_left  = $signed({1'b0, pos_x}) - WALK_S;
    x_right = $signed({1'b0, pos_x}) + WALK_S;
    x_next  = pos_x;
    if (left_only)
      x_next = (x_left < X_MIN_S) ? 10'(X_MIN) : x_left[9:0];
    else if (right_only)
      x_next = (x_right > X_MAX_S) ? 10'(X_MAX) : x_right[9:0];

    y_calc  = $signed({1'b0, pos_y}) + $signed({{5{vy[5]}}, vy});
    vy_sum  = vy + GRAV_S;
    vy_fall = (vy_sum > FALL_S) ? FALL_S : vy_sum;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      move_state  <= IDLE;
      pos_x       <= 10'(SPAWN_X);
      pos_y       <= 10'(GROUND_Y);
      vy          <= '0;
      facing_left <= 1'b0;
      on_ground   <= 1'b1;
      jump_prev   <= 1'b1;  // a button held through reset must not launch a jump
    end else if (frame_tick) begin
      jump_prev <= btn_jump;
      pos_x     <= x_next;
      if (left_only)
        facing_left <= 1'b1;
      else if (right_only)
        facing_left <= 1'b0;

      case (move_state)
        JUMP: begin
          if (y_calc >= GROUND_S) begin
            // landing tick ignores the jump edge
            pos_y      <= 10'(GROUND_Y);
            vy         <= '0;
            move_state <= ground_state;
            on_ground  <= 1'b1;
          end else if (y_calc < 11'sd0) begin
            pos_y     <= '0;
            vy        <= '0;
            on_ground <= 1'b0;
          end else begin
            pos_y     <= y_calc[9:0];
            vy        <= vy_fall;
            on_ground <= 1'b0;
          end
        end
        default: begin
          if (jump_edge) begin
            move_state <= JUMP;
            vy         <= -JUMP_S;
            on_ground  <= 1'b0;
          end else begin
            move_state <= ground_state;
            on_ground  <= (pos_y == 10'(GROUND_Y));
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_movement_fsm.sv
// Random and directed stimulus for player_movement_fsm, checked against a
// per-frame integer model of the movement rules.
module tb_player_movement_fsm;
  import game_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_tick = 1'b0;
  logic          btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
  movement_state move_state;
  logic [9:0]    pos_x, pos_y;
  logic          facing_left, on_ground;

  int checks = 0;
  int errors = 0;

  movement_state m_state;
  int            m_x, m_y, m_vy;
  bit            m_face, m_jprev;

  always #5 clk = ~clk;

  player_movement_fsm dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .move_state(move_state), .pos_x(pos_x), .pos_y(pos_y),
    .facing_left(facing_left), .on_ground(on_ground)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = IDLE; m_x = SPAWN_X; m_y = GROUND_Y;
    m_vy = 0; m_face = 0; m_jprev = 1;
  endtask

  // One frame of the movement rules, in plain integer arithmetic.
  task automatic model_tick(input bit l, input bit r, input bit j);
    bit lo, ro, edge_j;
    int ny;
    lo = l && !r;
    ro = r && !l;
    edge_j = j && !m_jprev;
    m_jprev = j;
    if (lo) m_x = (m_x - WALK_SPEED < X_MIN) ? X_MIN : m_x - WALK_SPEED;
    if (ro) m_x = (m_x + WALK_SPEED > X_MAX) ? X_MAX : m_x + WALK_SPEED;
    if (lo) m_face = 1;
    if (ro) m_face = 0;
    if (m_state == JUMP) begin
      ny = m_y + m_vy;
      if (ny >= GROUND_Y) begin
        m_y = GROUND_Y; m_vy = 0;
        m_state = (lo || ro) ? WALK : IDLE;
      end else if (ny < 0) begin
        m_y = 0; m_vy = 0;
      end else begin
        m_y = ny;
        m_vy = (m_vy + GRAVITY > MAX_FALL) ? MAX_FALL : m_vy + GRAVITY;
      end
    end else if (edge_j) begin
      m_state = JUMP; m_vy = -JUMP_VEL;
    end else begin
      m_state = (lo || ro) ? WALK : IDLE;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_state"}, int'(move_state), int'(m_state));
    chk({tag, "_x"}, int'(pos_x), m_x);
    chk({tag, "_y"}, int'(pos_y), m_y);
    chk({tag, "_face"}, int'(facing_left), int'(m_face));
    chk({tag, "_gnd"}, int'(on_ground), int'(m_y == GROUND_Y && m_state != JUMP));
  endtask

  task automatic step(input bit t, input bit l, input bit r, input bit j);
    @(negedge clk);
    frame_tick = t; btn_left = l; btn_right = r; btn_jump = j;
    @(posedge clk);
    if (t) model_tick(l, r, j);
    #1 check_all("step");
  endtask

  // Reset asserted between clock edges; outputs must change immediately.
  task automatic async_reset();
    @(negedge clk);
    frame_tick = 1'b0;
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("rst");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit l, r, j;
    // Reset with jump held: no jump until release and re-press
    btn_jump = 1'b1;
    #12 model_reset();
    check_all("por");
    chk("por_x_const", int'(pos_x), 300);
    chk("por_y_const", int'(pos_y), 400);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
    chk("held_no_jump", int'(move_state), int'(IDLE));

    // Right for 4 ticks then release
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0);
    chk("r4_state", int'(move_state), int'(WALK));
    chk("r4_x", int'(pos_x), 312);
    chk("r4_face", int'(facing_left), 0);
    step(1, 0, 0, 0);
    chk("rel_state", int'(move_state), int'(IDLE));
    chk("rel_x", int'(pos_x), 312);

    // Single-tick jump: apex on tick 12, landing on tick 27
    step(1, 0, 0, 1);
    chk("takeoff_state", int'(move_state), int'(JUMP));
    chk("takeoff_gnd", int'(on_ground), 0);
    for (int k = 1; k <= 27; k++) begin
      step(1, 0, 0, 0);
      if (k == 12) chk("apex_y", int'(pos_y), 322);
      if (k == 26) chk("pre_land_state", int'(move_state), int'(JUMP));
      if (k == 27) begin
        chk("land_state", int'(move_state), int'(IDLE));
        chk("land_y", int'(pos_y), 400);
      end
    end

    // Jump held through landing: no retrigger
    for (int k = 0; k < 32; k++) step(1, 0, 0, 1);
    chk("hold_land_state", int'(move_state), int'(IDLE));
    chk("hold_land_gnd", int'(on_ground), 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("rejump_state", int'(move_state), int'(JUMP));
    for (int k = 0; k < 27; k++) step(1, 0, 0, 0);

    // Left clamp at 0, then both buttons
    for (int k = 0; k < 110; k++) step(1, 1, 0, 0);
    chk("lclamp_x", int'(pos_x), 0);
    chk("lclamp_state", int'(move_state), int'(WALK));
    chk("lclamp_face", int'(facing_left), 1);
    step(1, 1, 1, 0);
    chk("both_state", int'(move_state), int'(IDLE));
    chk("both_face", int'(facing_left), 1);
    // Right clamp at X_MAX
    for (int k = 0; k < 200; k++) step(1, 0, 1, 0);
    chk("rclamp_x", int'(pos_x), 592);

    // Reset mid-jump, then a long stretch without ticks
    step(1, 0, 0, 1);
    for (int k = 0; k < 5; k++) step(1, 0, 1, 0);
    async_reset();
    for (int k = 0; k < 100; k++) step(0, k[0], k[1], k[2]);
    chk("idle_hold_x", int'(pos_x), 300);

    // Randomized frames with occasional resets
    j = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) async_reset();
      else begin
        l = ($urandom_range(0, 2) == 0);
        r = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 5) == 0) j = !j;
        step($urandom_range(0, 2) == 0, l, r, j);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
